// File: rtl/karlsen_ladder_mc_pkg.sv
// Shared types and helpers for the time-multiplexed Karlsen ladder filter.
package karlsen_pkg;

  // Per-channel output tap selection
  typedef enum logic [1:0] {
    MODE_LP  = 2'd0,
    MODE_LP2 = 2'd1,
    MODE_HP  = 2'd2,
    MODE_BYP = 2'd3
  } mode_t;

  // Sweep sequencer states; FB..POLE repeat once per channel
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FB    = 3'd1,
    CLIPA = 3'd2,
    CLIPB = 3'd3,
    POLE  = 3'd4,
    DONE  = 3'd5
  } fsm_t;

  // Default magnitude of the resonant feedback clip
  localparam int CLIP_LVL_DEF = 32000;

  // Clamp a wide signed value into the range of a w-bit signed word
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/karlsen_ladder_mc_mix.sv
// Shared interpolating multiplier: y = a + (((b - a) * s) >>> W).
module karlsen_mix #(
  parameter int W = 16
) (
  input  logic signed [2*W-1:0] a_i,
  input  logic signed [2*W-1:0] b_i,
  input  logic signed [2*W-1:0] s_i,
  output logic signed [2*W-1:0] y_o
);

  logic signed [2*W:0]   diff;
  logic signed [4*W+1:0] prod;

  // Full-width difference and product so the arithmetic shift never sees a wrapped value
  always_comb begin
    diff = $signed({b_i[2*W-1], b_i}) - $signed({a_i[2*W-1], a_i});
    prod = (4*W+2)'(diff) * (4*W+2)'(s_i);
    y_o  = a_i + (2*W)'(prod >>> W);
  end

endmodule

// File: rtl/karlsen_ladder_mc.sv
// N-channel Karlsen ladder low-pass filter sharing one mix multiplier across all channels and poles.
module karlsen_ladder_mc
  import karlsen_pkg::*;
#(
  parameter int W        = 16,
  parameter int N_CH     = 4,
  parameter int POLES    = 4,
  parameter int CLIP_LVL = CLIP_LVL_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic [N_CH*W-1:0]   sample_in,
  input  logic [N_CH*W-1:0]   g,
  input  logic [N_CH*W-1:0]   resonance,
  input  logic [N_CH*2-1:0]   mode,
  output logic [N_CH*W-1:0]   sample_out,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int DW      = 2 * W;
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PL_W    = (POLES > 1) ? $clog2(POLES) : 1;
  localparam int LP2_IDX = (POLES > 2) ? 1 : 0;
  localparam logic signed [DW-1:0] CLIP_P    = DW'(CLIP_LVL);
  localparam logic signed [DW-1:0] CLIP_N    = -CLIP_P;
  localparam logic [CH_W-1:0]      LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [PL_W-1:0]      LAST_POLE = PL_W'(POLES - 1);

  fsm_t state_q, state_d;

  logic armed_q, prev_q, toggle;
  logic [CH_W-1:0] ch_q;
  logic [PL_W-1:0] pole_q, pole_nx;
  logic last_pole, last_ch, mid_sweep;

  logic do_start, do_restart, do_fb_ops, do_clipa, do_clipb, do_pole, do_commit, do_done;

  logic signed [W-1:0] x_sh_q   [N_CH];
  logic [W-1:0]        g_sh_q   [N_CH];
  logic [W-1:0]        res_sh_q [N_CH];
  mode_t               mode_sh_q[N_CH];

  logic signed [DW-1:0] op_a_q, op_b_q, op_s_q, mix_y;
  logic signed [DW-1:0] fb_q, fb_clamped;
  logic signed [DW-1:0] stage_q   [POLES];
  logic signed [DW-1:0] pole_st_q [N_CH][POLES];

  logic signed [DW-1:0] x_ex, g_ex, res_ex, a_last, a_first, a_next, tap_sel;
  logic signed [W-1:0]  tap_sat;

  logic signed [W-1:0] out_sh_q     [N_CH];
  logic signed [W-1:0] sample_out_q [N_CH];
  logic out_valid_q, busy_q, overrun_q;

  karlsen_mix #(.W(W)) u_mix (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .s_i (op_s_q),
    .y_o (mix_y)
  );

  assign toggle    = armed_q && (sample_clk != prev_q);
  assign last_pole = (pole_q == LAST_POLE);
  assign last_ch   = (ch_q == LAST_CH);
  assign pole_nx   = pole_q + 1'b1;
  assign mid_sweep = (state_q == FB) || (state_q == CLIPA) || (state_q == CLIPB) || (state_q == POLE);

  // Track the strobe level; the first cycle after reset only arms, and DONE holds the level so a late toggle survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (!armed_q || state_q != DONE) begin
        prev_q <= sample_clk;
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next state; a toggle mid-sweep restarts at the first channel
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (toggle) state_d = FB;
      FB:      state_d = CLIPA;
      CLIPA:   state_d = CLIPB;
      CLIPB:   state_d = POLE;
      POLE:    if (last_pole) state_d = last_ch ? DONE : FB;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (toggle && mid_sweep) begin
      state_d = FB;
    end
  end

  // Sequencer action strobes; a restart suppresses every datapath action of the aborted step
  always_comb begin
    do_start   = 1'b0;
    do_restart = 1'b0;
    do_fb_ops  = 1'b0;
    do_clipa   = 1'b0;
    do_clipb   = 1'b0;
    do_pole    = 1'b0;
    do_commit  = 1'b0;
    do_done    = 1'b0;
    case (state_q)
      IDLE:    do_start  = toggle;
      FB:      do_fb_ops = 1'b1;
      CLIPA:   do_clipa  = 1'b1;
      CLIPB:   do_clipb  = 1'b1;
      POLE: begin
        do_pole   = 1'b1;
        do_commit = last_pole;
      end
      DONE:    do_done   = 1'b1;
      default: do_done   = 1'b0;
    endcase
    if (toggle && mid_sweep) begin
      do_start   = 1'b1;
      do_restart = 1'b1;
      do_fb_ops  = 1'b0;
      do_clipa   = 1'b0;
      do_clipb   = 1'b0;
      do_pole    = 1'b0;
      do_commit  = 1'b0;
    end
  end

  // Operand selection, feedback clamp and output tap for the channel currently being swept
  always_comb begin
    x_ex    = DW'(x_sh_q[ch_q]);
    g_ex    = $signed({{W{1'b0}}, g_sh_q[ch_q]});
    res_ex  = $signed({{W{1'b0}}, res_sh_q[ch_q]} << 2);
    a_last  = pole_st_q[ch_q][POLES-1];
    a_first = pole_st_q[ch_q][0];
    a_next  = last_pole ? '0 : pole_st_q[ch_q][pole_nx];
    if (fb_q > CLIP_P) begin
      fb_clamped = CLIP_P;
    end else if (fb_q < CLIP_N) begin
      fb_clamped = CLIP_N;
    end else begin
      fb_clamped = fb_q;
    end
    case (mode_sh_q[ch_q])
      MODE_LP:  tap_sel = mix_y;
      MODE_LP2: tap_sel = (POLES > 2) ? stage_q[LP2_IDX] : mix_y;
      MODE_HP:  tap_sel = fb_q - mix_y;
      MODE_BYP: tap_sel = x_ex;
      default:  tap_sel = mix_y;
    endcase
    tap_sat = W'(sat_w(64'(tap_sel), W));
  end

  // Snapshot all channel inputs at the start of every sweep, clamping negative coefficients to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        x_sh_q[k]    <= '0;
        g_sh_q[k]    <= '0;
        res_sh_q[k]  <= '0;
        mode_sh_q[k] <= MODE_LP;
      end
    end else if (do_start) begin
      for (int k = 0; k < N_CH; k++) begin
        x_sh_q[k]    <= sample_in[k*W +: W];
        g_sh_q[k]    <= g[k*W+W-1] ? '0 : g[k*W +: W];
        res_sh_q[k]  <= resonance[k*W+W-1] ? '0 : resonance[k*W +: W];
        mode_sh_q[k] <= mode_t'(mode[k*2 +: 2]);
      end
    end
  end

  // Channel/pole counters plus the busy and sticky overrun flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q      <= '0;
      pole_q    <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (do_start) begin
      ch_q   <= '0;
      pole_q <= '0;
      busy_q <= 1'b1;
      if (do_restart) begin
        overrun_q <= 1'b1;
      end
    end else begin
      if (do_pole) begin
        if (last_pole) begin
          pole_q <= '0;
          if (!last_ch) begin
            ch_q <= ch_q + 1'b1;
          end
        end else begin
          pole_q <= pole_nx;
        end
      end
      if (do_done) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Mix operands, feedback register and per-pole staging for the channel in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
      op_s_q <= '0;
      fb_q   <= '0;
      for (int p = 0; p < POLES; p++) begin
        stage_q[p] <= '0;
      end
    end else begin
      if (do_fb_ops) begin
        op_a_q <= x_ex;
        op_b_q <= a_last;
        op_s_q <= res_ex;
      end
      if (do_clipa) begin
        fb_q <= (x_ex <<< 1) - mix_y;
      end
      if (do_clipb) begin
        fb_q   <= fb_clamped;
        op_a_q <= a_first;
        op_b_q <= fb_clamped;
        op_s_q <= g_ex;
      end
      if (do_pole) begin
        stage_q[pole_q] <= mix_y;
        op_a_q          <= a_next;
        op_b_q          <= mix_y;
        op_s_q          <= g_ex;
      end
    end
  end

  // Commit the staged ladder into the channel's pole state only once the whole channel finished
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        for (int p = 0; p < POLES; p++) begin
          pole_st_q[k][p] <= '0;
        end
      end
    end else if (do_commit) begin
      for (int p = 0; p < POLES - 1; p++) begin
        pole_st_q[ch_q][p] <= stage_q[p];
      end
      pole_st_q[ch_q][POLES-1] <= mix_y;
    end
  end

  // Per-channel result shadow, published to the outputs together when the sweep completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        out_sh_q[k]     <= '0;
        sample_out_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= do_done;
      if (do_commit) begin
        out_sh_q[ch_q] <= tap_sat;
      end
      if (do_done) begin
        for (int k = 0; k < N_CH; k++) begin
          sample_out_q[k] <= out_sh_q[k];
        end
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_out
    assign sample_out[k*W +: W] = sample_out_q[k];
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_karlsen_ladder_mc.sv
// Self-checking bench for karlsen_ladder_mc against a sample-level reference model.
module tb_karlsen_ladder_mc;

  localparam int W    = 16;
  localparam int N_CH = 4;
  localparam int POLES = 4;
  localparam int CLIP = 32000;
  localparam int LAT  = N_CH * (POLES + 3) + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic [N_CH*W-1:0] sample_in = '0;
  logic [N_CH*W-1:0] g = '0;
  logic [N_CH*W-1:0] resonance = '0;
  logic [N_CH*2-1:0] mode = '0;
  logic [N_CH*W-1:0] sample_out;
  logic out_valid, busy, overrun;

  int nChecks = 0;
  int nPass = 0;

  longint st[N_CH][POLES];
  longint expOut[N_CH];
  longint sx[N_CH];
  longint sg[N_CH];
  longint sr[N_CH];
  int     sm[N_CH];

  always #5 clk = ~clk;

  karlsen_ladder_mc #(.W(W), .N_CH(N_CH), .POLES(POLES), .CLIP_LVL(CLIP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_clk (sclk),
    .sample_in  (sample_in),
    .g          (g),
    .resonance  (resonance),
    .mode       (mode),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    nChecks++;
    if (obs == exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint outCh(input int k);
    logic signed [W-1:0] v;
    v = sample_out[k*W +: W];
    return longint'(v);
  endfunction

  function automatic longint clampv(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint mixf(input longint a, input longint b, input longint s);
    return a + (((b - a) * s) >>> W);
  endfunction

  function automatic longint rnd16();
    return longint'($urandom_range(65535)) - 32768;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < N_CH; c++) begin
      expOut[c] = 0;
      for (int p = 0; p < POLES; p++) st[c][p] = 0;
    end
  endtask

  // One sample of one channel: clipped resonant feedback into a cascade of one-pole lowpasses
  task automatic modelChannel(input int c, output longint y);
    longint gg, rr, fb, inp, tap;
    gg = (sg[c] < 0) ? 0 : sg[c];
    rr = ((sr[c] < 0) ? 0 : sr[c]) * 4;
    fb = 2 * sx[c] - mixf(sx[c], st[c][POLES-1], rr);
    fb = clampv(fb, -CLIP, CLIP);
    inp = fb;
    for (int p = 0; p < POLES; p++) begin
      st[c][p] = mixf(st[c][p], inp, gg);
      inp = st[c][p];
    end
    case (sm[c])
      0: tap = st[c][POLES-1];
      1: tap = (POLES >= 2) ? st[c][1] : st[c][POLES-1];
      2: tap = fb - st[c][POLES-1];
      default: tap = sx[c];
    endcase
    y = clampv(tap, -32768, 32767);
  endtask

  task automatic modelSweep(input int nCh, input bit publish);
    longint y;
    for (int c = 0; c < nCh; c++) begin
      modelChannel(c, y);
      if (publish) expOut[c] = y;
    end
  endtask

  task automatic fillRandom();
    for (int c = 0; c < N_CH; c++) begin
      sx[c] = rnd16();
      sg[c] = rnd16();
      sr[c] = rnd16();
      sm[c] = int'($urandom_range(3));
    end
  endtask

  // Present the staged inputs and toggle the sample strobe
  task automatic applyStimulus();
    for (int c = 0; c < N_CH; c++) begin
      sample_in[c*W +: W] = W'(sx[c]);
      g[c*W +: W]         = W'(sg[c]);
      resonance[c*W +: W] = W'(sr[c]);
      mode[c*2 +: 2]      = 2'(sm[c]);
    end
    sclk = ~sclk;
  endtask

  task automatic waitValid(input int budget, output int lat);
    lat = 0;
    while (lat < budget) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic checkAll(input string tag);
    for (int c = 0; c < N_CH; c++) begin
      checkOutput($sformatf("%s_ch%0d", tag, c), outCh(c), expOut[c]);
    end
  endtask

  // Full sample: drive, wait for completion, compare latency and all channels with the model
  task automatic doSample(input string tag);
    int lat;
    applyStimulus();
    waitValid(100, lat);
    checkOutput({tag, "_lat"}, lat, LAT);
    modelSweep(N_CH, 1'b1);
    checkAll(tag);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int pulses;
    longint prev, o;

    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("rst_out");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_valid", out_valid, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted in the middle of a sweep
    fillRandom();
    doSample("pre");
    fillRandom();
    applyStimulus();
    repeat (12) @(posedge clk);
    #1;
    checkOutput("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("midrst_out");
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_overrun", overrun, 0);
    checkOutput("midrst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checkOutput("midrst_no_valid", pulses, 0);
    checkOutput("midrst_idle_busy", busy, 0);

    // DC step on channel 0 through the 4-pole lowpass
    doReset();
    for (int c = 0; c < N_CH; c++) begin
      sx[c] = 0; sg[c] = 0; sr[c] = 0; sm[c] = 0;
    end
    sx[0] = 10000;
    sg[0] = 32767;
    prev = 0;
    for (int i = 0; i < 64; i++) begin
      doSample("dc");
      o = outCh(0);
      checkOutput("dc_mono", (o >= prev) ? 1 : 0, 1);
      checkOutput("dc_no_overshoot", (o <= 10000) ? 1 : 0, 1);
      prev = o;
    end
    o = outCh(0);
    checkOutput("dc_settle", (o >= 10000 - 2 * POLES) ? 1 : 0, 1);

    // Full-scale square wave with strong resonance; HP on channel 1 hits output saturation
    for (int c = 0; c < N_CH; c++) begin
      sx[c] = 0; sg[c] = 0; sr[c] = 0; sm[c] = 0;
    end
    sg[0] = 20000; sr[0] = 16384; sm[0] = 0;
    sg[1] = 30000; sr[1] = 32767; sm[1] = 2;
    for (int i = 0; i < 24; i++) begin
      sx[0] = ((i / 4) % 2 == 0) ? 30000 : -30000;
      sx[1] = -sx[0];
      doSample("res");
    end

    // Only channel 1 carries signal; the others must stay exactly zero
    doReset();
    for (int i = 0; i < 16; i++) begin
      fillRandom();
      for (int c = 0; c < N_CH; c++) sx[c] = 0;
      sx[1] = ($urandom_range(1) == 0) ? 20000 : -20000;
      doSample("iso");
      checkOutput("iso_ch0", outCh(0), 0);
      checkOutput("iso_ch2", outCh(2), 0);
      checkOutput("iso_ch3", outCh(3), 0);
    end

    // Each tap on a settled DC input
    doReset();
    for (int c = 0; c < N_CH; c++) begin
      sx[c] = 8000; sg[c] = 32767; sr[c] = 0; sm[c] = c;
    end
    for (int i = 0; i < 64; i++) doSample("mode");
    checkOutput("mode_valid", out_valid, 1);
    checkOutput("mode_byp", outCh(3), 8000);

    // Second toggle 10 cycles into a sweep
    doReset();
    pulses = 0;
    fillRandom();
    applyStimulus();
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    modelSweep((10 - 1) / (POLES + 3), 1'b0);
    fillRandom();
    applyStimulus();
    waitValid(100, lat);
    if (lat > 0) pulses++;
    checkOutput("ovr_lat", lat, LAT);
    checkOutput("ovr_flag", overrun, 1);
    modelSweep(N_CH, 1'b1);
    checkAll("ovr");
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    checkOutput("ovr_pulses", pulses, 1);
    fillRandom();
    doSample("ovr_after");
    checkOutput("ovr_sticky", overrun, 1);

    // Toggle arriving in the completion cycle
    doReset();
    fillRandom();
    applyStimulus();
    pulses = 0;
    repeat (LAT - 1) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    modelSweep(N_CH, 1'b1);
    fillRandom();
    applyStimulus();
    @(posedge clk);
    #1;
    checkOutput("done_tog_first_valid", out_valid, 1);
    checkOutput("done_tog_early", pulses, 0);
    checkAll("done_tog_a");
    waitValid(100, lat);
    checkOutput("done_tog_lat", (lat > 0) ? lat + 1 : -1, LAT + 1);
    modelSweep(N_CH, 1'b1);
    checkAll("done_tog_b");
    checkOutput("done_tog_overrun", overrun, 0);

    // Random traffic on all channels, coefficients and modes
    for (int i = 0; i < 40; i++) begin
      fillRandom();
      doSample("rnd");
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
